// File: rtl/mux_pkg.sv
// Shared definitions for the scanning channel multiplexer: mode encodings and
// the select-width helper used to size channel indices.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width of an index able to address n items, never narrower than one bit.
  function automatic int selw_of(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Combinational round-robin finder: the first enabled channel strictly after
// i_ch, wrapping, or i_ch itself when it is the only enabled one.
module mux_next_ch
  import mux_pkg::*;
#(
  parameter int CHANNELS = 12,
  localparam int SELW = selw_of(CHANNELS)
) (
  input  logic [SELW-1:0]     i_ch,
  input  logic [CHANNELS-1:0] i_mask,
  output logic [SELW-1:0]     o_next,
  output logic                o_none
);

  logic            w_found_hi;
  logic            w_found_lo;
  logic [SELW-1:0] w_hi;
  logic [SELW-1:0] w_lo;

  // w_hi: first enabled above i_ch; w_lo: first enabled overall (wrap target).
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (i_mask[j]) begin
        if (!w_found_hi && (SELW'(j) > i_ch)) begin
          w_found_hi = 1'b1;
          w_hi       = SELW'(j);
        end
        if (!w_found_lo) begin
          w_found_lo = 1'b1;
          w_lo       = SELW'(j);
        end
      end
    end
  end

  assign o_next = w_found_hi ? w_hi : (w_found_lo ? w_lo : i_ch);
  assign o_none = ~w_found_lo;

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N:1 channel mux with manual select or round-robin auto-scan.
// Define MUX_SKIP_MASK_EN to add the ch_mask port for skipping channels.
module mux_scan_sel
  import mux_pkg::*;
#(
  parameter int CHANNELS = 12,
  parameter int WIDTH    = 1,
  parameter int DWELL    = 1,
  localparam int SELW    = selw_of(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      enable,
`ifdef MUX_SKIP_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]          out,
  output logic [SELW-1:0]           ch,
  output logic                      ch_strobe,
  output logic                      sel_err
);

  localparam int CNTW = selw_of(DWELL);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  logic [CHANNELS-1:0] w_mask;
  logic [WIDTH-1:0]    w_cur_data;
  logic [WIDTH-1:0]    w_sel_data;
  logic                w_sel_ok;
  logic [SELW-1:0]     w_next_ch;
  logic                w_none;

  logic [SELW-1:0]     r_ch;
  logic [CNTW-1:0]     r_cnt;
  logic [WIDTH-1:0]    r_out;
  logic                r_strobe;
  logic                r_err;

`ifdef MUX_SKIP_MASK_EN
  assign w_mask = ch_mask;
`else
  assign w_mask = '1;
`endif

  // Compare-based selection so an out-of-range sel never indexes past in_bus.
  always_comb begin
    w_cur_data = '0;
    w_sel_data = '0;
    w_sel_ok   = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_ch == SELW'(k)) w_cur_data = in_bus[k*WIDTH +: WIDTH];
      if (sel == SELW'(k)) begin
        w_sel_data = in_bus[k*WIDTH +: WIDTH];
        w_sel_ok   = w_mask[k];
      end
    end
  end

  mux_next_ch #(
    .CHANNELS (CHANNELS)
  ) u_next_ch (
    .i_ch   (r_ch),
    .i_mask (w_mask),
    .o_next (w_next_ch),
    .o_none (w_none)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch     <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_strobe <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (!enable) begin
        r_out <= w_cur_data;
      end else if (mode == MODE_MANUAL) begin
        // Counter kept cleared so a switch to scan starts a full dwell.
        r_cnt <= '0;
        if (w_sel_ok) begin
          r_ch     <= sel;
          r_out    <= w_sel_data;
          r_err    <= 1'b0;
          r_strobe <= (sel != r_ch);
        end else begin
          r_out <= '0;
          r_err <= 1'b1;
        end
      end else begin
        r_err <= 1'b0;
        r_out <= w_none ? '0 : w_cur_data;
        if (r_cnt == CNT_LAST) begin
          r_cnt    <= '0;
          r_ch     <= w_next_ch;
          r_strobe <= (w_next_ch != r_ch);
        end else begin
          r_cnt <= r_cnt + CNTW'(1);
        end
      end
    end
  end

  assign out       = r_out;
  assign ch        = r_ch;
  assign ch_strobe = r_strobe;
  assign sel_err   = r_err;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel (12 channels, 4-bit data, dwell 3) with a reference
// model and directed scenarios; mask scenarios run when MUX_SKIP_MASK_EN is set.
module tb_mux_scan_sel;

  localparam int CH = 12;
  localparam int W  = 4;
  localparam int DW = 3;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [CH*W-1:0] in_bus = '0;
  logic [SW-1:0]   sel = '0;
  logic            mode = 1'b0;
  logic            enable = 1'b1;
`ifdef MUX_SKIP_MASK_EN
  logic [CH-1:0]   ch_mask = '1;
`endif
  logic [W-1:0]    out;
  logic [SW-1:0]   ch;
  logic            ch_strobe;
  logic            sel_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  int m_ch = 0, m_cnt = 0, m_out = 0, m_strobe = 0, m_err = 0;

  always #5 clk = ~clk;

  mux_scan_sel #(.CHANNELS(CH), .WIDTH(W), .DWELL(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus),
    .sel       (sel),
    .mode      (mode),
    .enable    (enable),
`ifdef MUX_SKIP_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .out       (out),
    .ch        (ch),
    .ch_strobe (ch_strobe),
    .sel_err   (sel_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [CH-1:0] eff_mask();
`ifdef MUX_SKIP_MASK_EN
    return ch_mask;
`else
    return '1;
`endif
  endfunction

  function automatic int inval(input int k);
    return int'(in_bus[k*W +: W]);
  endfunction

  function automatic int next_en(input int c, input logic [CH-1:0] m);
    for (int s = 1; s <= CH; s++)
      if (m[(c + s) % CH]) return (c + s) % CH;
    return c;
  endfunction

  // Reference model: what the registered outputs must hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ch = 0; m_cnt = 0; m_out = 0; m_strobe = 0; m_err = 0;
    end else begin
      int nxt;
      logic [CH-1:0] m;
      m   = eff_mask();
      nxt = m_ch;
      if (!enable) begin
        m_out = inval(m_ch);
      end else if (mode == 1'b0) begin
        m_cnt = 0;
        if (int'(sel) < CH && m[int'(sel)]) begin
          nxt = int'(sel); m_out = inval(int'(sel)); m_err = 0;
        end else begin
          m_out = 0; m_err = 1;
        end
      end else begin
        m_err = 0;
        m_out = (m == '0) ? 0 : inval(m_ch);
        if (m_cnt == DW - 1) begin
          m_cnt = 0;
          nxt = next_en(m_ch, m);
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      m_strobe = (nxt != m_ch) ? 1 : 0;
      m_ch = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_out", out, m_out);
      chk("model_ch", ch, m_ch);
      chk("model_strobe", ch_strobe, m_strobe);
      chk("model_sel_err", sel_err, m_err);
    end
  end

  initial begin
    int wrap_exp[6] = '{10, 10, 11, 11, 11, 0};
    for (int k = 0; k < CH; k++) in_bus[k*W +: W] = W'(k + 1);

    #1 rst_n = 1'b0;
    #1;
    chk("reset_out", out, 0);
    chk("reset_ch", ch, 0);
    chk("reset_strobe", ch_strobe, 0);
    chk("reset_err", sel_err, 0);
    chk_on = 1'b1;
    mode   = 1'b1;
    #5 rst_n = 1'b1;

    // Scan up to ch=5, then pull reset between edges.
    for (int i = 0; i < 100 && m_ch != 5; i++) step(1);
    chk("reach_ch5", ch, 5);
    chk("strobe_at_5", ch_strobe, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 0);
    chk("async_rst_ch", ch, 0);
    chk("async_rst_strobe", ch_strobe, 0);
    #1 rst_n = 1'b1;
    step(2);
    chk("resume_ch0", ch, 0);
    step(1);
    chk("resume_ch1", ch, 1);
    chk("resume_strobe", ch_strobe, 1);

    // Manual select and hold.
    mode = 1'b0; sel = 4'd7;
    step(1);
    chk("man_ch7", ch, 7);
    chk("man_out8", out, 8);
    chk("man_strobe", ch_strobe, 1);
    step(1);
    chk("man_hold_strobe", ch_strobe, 0);
    chk("man_hold_ch", ch, 7);

    // Out-of-range select then recovery.
    sel = 4'd13;
    step(1);
    chk("oor_ch", ch, 7);
    chk("oor_out", out, 0);
    chk("oor_err", sel_err, 1);
    sel = 4'd2;
    step(1);
    chk("rec_ch", ch, 2);
    chk("rec_out", out, 3);
    chk("rec_err", sel_err, 0);

    // Scan wrap from ch=10.
    sel = 4'd10;
    step(1);
    chk("pre_wrap_ch", ch, 10);
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("wrap_seq", ch, wrap_exp[i]);
    end
    chk("wrap_strobe", ch_strobe, 1);

    // Freeze stretches the dwell by the frozen cycles.
    step(1);
    enable = 1'b0;
    step(4);
    chk("freeze_ch", ch, 0);
    enable = 1'b1;
    step(1);
    chk("stretch_ch0", ch, 0);
    step(1);
    chk("stretch_ch1", ch, 1);

    // Data tracking while parked on ch=4.
    for (int i = 0; i < 100 && m_ch != 4; i++) step(1);
    chk("reach_ch4", ch, 4);
    in_bus[4*W +: W] = 4'd9;
    step(1);
    chk("track_out", out, 9);
    chk("track_ch", ch, 4);
    chk("track_strobe", ch_strobe, 0);
    in_bus[4*W +: W] = 4'd5;

    // Select boundaries and sel_err hold while frozen.
    mode = 1'b0; sel = 4'd12;
    step(1);
    chk("sel12_err", sel_err, 1);
    chk("sel12_out", out, 0);
    sel = 4'd11;
    step(1);
    chk("sel11_ch", ch, 11);
    chk("sel11_out", out, 12);
    sel = 4'd13;
    step(1);
    enable = 1'b0; sel = 4'd2;
    step(1);
    chk("frozen_err", sel_err, 1);
    chk("frozen_ch", ch, 11);
    chk("frozen_out", out, 12);
    enable = 1'b1;
    step(1);
    chk("unfrozen_ch", ch, 2);
    chk("unfrozen_err", sel_err, 0);

`ifdef MUX_SKIP_MASK_EN
    sel = 4'd1;
    step(1);
    chk("mask_start", ch, 1);
    ch_mask = 12'b0000_1000_0010;
    mode = 1'b1;
    step(2);
    chk("mask_dwell", ch, 1);
    step(1);
    chk("mask_ch7", ch, 7);
    step(3);
    chk("mask_ch1", ch, 1);
    step(3);
    chk("mask_ch7b", ch, 7);
    ch_mask = '0;
    step(1);
    chk("mask_none_ch", ch, 7);
    chk("mask_none_out", out, 0);
    ch_mask = 12'b0000_1000_0010;
    mode = 1'b0; sel = 4'd3;
    step(1);
    chk("masked_sel_err", sel_err, 1);
    chk("masked_sel_ch", ch, 7);
`endif

    step(1);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
